noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/noc_output_arbiter.sv | 140 ++++++++++++++
 tb/tb_noc_output_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for a NoC router: round-robin packet ownership between
// requesters, with a single registered flit stage toward the downstream link.
module noc_output_arbiter #(
  parameter int REQUESTERS = 5,
  parameter int FLIT_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS-1:0]            i_request,
  input  logic [REQUESTERS-1:0]            i_free,
  output logic [REQUESTERS-1:0]            o_grant,
  input  logic [REQUESTERS-1:0]            i_valid,
  output logic [REQUESTERS-1:0]            o_ready,
  input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [FLIT_WIDTH-1:0]            o_flit
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        gidx;
  logic                    release_w;
  logic                    accept_w;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    valid_q, valid_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;

  // Round-robin pick: first requester at base+1, base+2, ... (mod REQUESTERS).
  function automatic logic [REQUESTERS-1:0] pick_next(
    input logic [REQUESTERS-1:0] req,
    input logic [PTR_W-1:0]      base
  );
    logic [REQUESTERS-1:0] g;
    logic                  found;
    int                    idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = (int'(base) + i) % REQUESTERS;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    gidx     = '0;
    sel_flit = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
      sel_flit = sel_flit | ({FLIT_WIDTH{grant_q[i]}} & i_flit[i*FLIT_WIDTH +: FLIT_WIDTH]);
    end
  end

  assign release_w = (state_q == BUSY) && |(i_free & grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|i_request) begin
          grant_d = pick_next(i_request, ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // On release the search restarts just past the owner that let go.
        if (release_w) begin
          ptr_d = gidx;
          if (|i_request) begin
            grant_d = pick_next(i_request, gidx);
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    o_ready  = grant_q & {REQUESTERS{~valid_q | i_ready}};
    accept_w = |(i_valid & o_ready);
  end

  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    if (accept_w) begin
      valid_d = 1'b1;
      flit_d  = sel_flit;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register drains independently of ownership changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flit_q  <= flit_d;
    end
  end

  assign o_grant = grant_q;
  assign o_valid = valid_q;
  assign o_flit  = flit_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: cycle-tagged expectations and a flit
// scoreboard are filled by the stimulus and consumed by an independent monitor.
module tb_noc_output_arbiter;
  localparam int N  = 5;
  localparam int FW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_request, i_free, i_valid;
  logic [N-1:0]    o_grant, o_ready;
  logic [N*FW-1:0] i_flit;
  logic            o_valid;
  logic            i_ready;
  logic [FW-1:0]   o_flit;

  noc_output_arbiter #(.REQUESTERS(N), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_free(i_free), .o_grant(o_grant),
    .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
    .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 grant, 1 valid, 2 ready, 3 flit
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t          expq[$];
  logic [FW-1:0] flitq[$];
  int            cyc = 0;
  int            checks = 0;
  int            passed = 0;
  logic          done = 1'b0;
  logic          final_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc + dly; e.kind = kind; e.val = val; e.name = name;
    expq.push_back(e);
  endtask

  task automatic set_flit(input int k, input logic [FW-1:0] v);
    i_flit[k*FW +: FW] = v;
  endtask

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0:       return 32'(o_grant);
      1:       return 32'(o_valid);
      2:       return 32'(o_ready);
      default: return 32'(o_flit);
    endcase
  endfunction

  // Monitor: consumes expectations due this cycle and every transferred flit.
  always @(negedge clk) begin
    logic [31:0] a;
    logic [FW-1:0] f;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      checks++;
      a = actual(expq[0].kind);
      if (expq[0].cyc == cyc && a == expq[0].val) passed++;
      else $display("FAIL %s @cyc %0d: got %h, expected %h", expq[0].name, cyc, a, expq[0].val);
      void'(expq.pop_front());
    end
    if (!rst && o_valid && i_ready) begin
      checks++;
      if (flitq.size() == 0) begin
        $display("FAIL unexpected_flit @cyc %0d: got %h, expected none", cyc, o_flit);
      end else begin
        f = flitq.pop_front();
        if (o_flit == f) passed++;
        else $display("FAIL flit_order @cyc %0d: got %h, expected %h", cyc, o_flit, f);
      end
    end
    if (done && !final_done) begin
      checks += 2;
      if (flitq.size() == 0) passed++;
      else $display("FAIL flits_delivered: %0d left, expected 0", flitq.size());
      if (expq.size() == 0) passed++;
      else $display("FAIL expectations_consumed: %0d left, expected 0", expq.size());
      final_done <= 1'b1;
    end
  end

  initial begin
    rst = 1'b1; i_request = '0; i_free = '0; i_valid = '0; i_flit = '0; i_ready = 1'b0;
    step(); step();

    // Reset state, then first arbitration from index 0
    step(); rst = 1'b0; i_request = 5'b10100;
    expect_at(0, 0, 32'h00, "reset_grant"); expect_at(0, 1, 32'h0, "reset_valid");
    expect_at(0, 2, 32'h00, "reset_ready"); expect_at(0, 3, 32'h0, "reset_flit");
    expect_at(1, 0, 32'h04, "first_grant");
    step(); i_request = 5'b11111; expect_at(1, 0, 32'h04, "grant_hold");
    step(); i_free = 5'b00100;    expect_at(1, 0, 32'h08, "rr_2to3");
    step(); i_free = 5'b01000;    expect_at(1, 0, 32'h10, "rr_3to4");
    step(); i_free = 5'b10000;    expect_at(1, 0, 32'h01, "rr_wrap");
    step(); i_free = '0; i_request = '0;

    // Requester 0 streams four flits back to back
    step(); i_ready = 1'b1; i_valid = 5'b00001; set_flit(0, 16'hA001); flitq.push_back(16'hA001);
    expect_at(0, 2, 32'h01, "stream_ready");
    expect_at(1, 1, 32'h1, "stream_v1"); expect_at(1, 3, 32'hA001, "stream_f1");
    step(); set_flit(0, 16'hA002); flitq.push_back(16'hA002);
    expect_at(1, 1, 32'h1, "stream_v2"); expect_at(1, 3, 32'hA002, "stream_f2");
    step(); set_flit(0, 16'hA003); flitq.push_back(16'hA003);
    expect_at(1, 1, 32'h1, "stream_v3"); expect_at(1, 3, 32'hA003, "stream_f3");
    step(); set_flit(0, 16'hA004); flitq.push_back(16'hA004);
    expect_at(1, 1, 32'h1, "stream_v4"); expect_at(1, 3, 32'hA004, "stream_f4");
    // Backpressure: flit held, requester sees not-ready
    step(); i_ready = 1'b0; set_flit(0, 16'hB000);
    for (int i = 0; i < 3; i++) begin
      expect_at(0, 3, 32'hA004, "stall_flit"); expect_at(0, 1, 32'h1, "stall_valid");
      expect_at(0, 2, 32'h00, "stall_ready");
      if (i < 2) step();
    end
    step(); i_ready = 1'b1; i_valid = '0;
    expect_at(0, 2, 32'h01, "drain_ready"); expect_at(1, 1, 32'h0, "drain_valid");

    // Flit accepted alongside release; it stays pending after grant moves
    step(); i_ready = 1'b0; i_valid = 5'b00001; set_flit(0, 16'hC001); flitq.push_back(16'hC001);
    i_free = 5'b00001; i_request = 5'b00010;
    expect_at(0, 2, 32'h01, "free_accept_ready");
    expect_at(1, 0, 32'h02, "free_regrant"); expect_at(1, 1, 32'h1, "free_valid");
    expect_at(1, 3, 32'hC001, "free_flit"); expect_at(1, 2, 32'h00, "free_ready_off");
    step(); i_valid = '0; i_free = '0; i_request = '0;
    expect_at(1, 3, 32'hC001, "pending_hold"); expect_at(1, 1, 32'h1, "pending_valid");
    step(); i_ready = 1'b1;
    expect_at(0, 2, 32'h02, "new_owner_ready"); expect_at(1, 1, 32'h0, "pending_drained");

    // Foreign free ignored; owner free with no requests goes idle
    step(); i_free = 5'b01000; i_request = 5'b00100; expect_at(1, 0, 32'h02, "foreign_free");
    step(); i_free = 5'b00010; i_request = '0;       expect_at(1, 0, 32'h00, "release_idle");
    step(); i_free = 5'b11111;                       expect_at(1, 0, 32'h00, "idle_free_ignored");
    step(); i_free = '0; i_request = 5'b00011;       expect_at(1, 0, 32'h01, "rr_after_idle");

    // Reset mid-packet discards the pending flit and ownership
    step(); i_request = '0; i_valid = 5'b00001; set_flit(0, 16'hD001); i_ready = 1'b0;
    expect_at(1, 1, 32'h1, "pre_reset_valid");
    step(); rst = 1'b1; i_valid = '0;
    expect_at(1, 1, 32'h0, "rst_valid"); expect_at(1, 0, 32'h00, "rst_grant");
    expect_at(1, 3, 32'h0, "rst_flit");
    step(); rst = 1'b0; i_request = 5'b00011; i_ready = 1'b1;
    expect_at(0, 2, 32'h00, "post_rst_ready"); expect_at(1, 0, 32'h01, "post_rst_grant");
    step(); i_request = '0;
    step(); step();
    done = 1'b1;
    for (int i = 0; i < 20 && !final_done; i++) @(posedge clk);
    #1;
    if (!final_done) begin
      $display("FAIL monitor_final: got not done, expected done");
      checks++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
